// File: rtl/line_buffer_sequencer_pkg.sv
// Shared sizes, FSM state type and enable-decode helpers for the line buffer sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package line_buffer_sequencer_pkg;

  localparam int LINE_WIDTH = 512;  // pixels per image line
  localparam int NUM_LINES  = 4;    // physical line buffers, must be >= WIN_ROWS+1
  localparam int WIN_ROWS   = 3;    // rows read in parallel per window column

  localparam int CNT_W  = $clog2(LINE_WIDTH);
  localparam int SEL_W  = $clog2(NUM_LINES);
  localparam int FILL_W = $clog2(NUM_LINES * LINE_WIDTH + 1);

  localparam logic [FILL_W-1:0] FILL_MAX    = FILL_W'(NUM_LINES * LINE_WIDTH);
  localparam logic [FILL_W-1:0] FILL_THRESH = FILL_W'(WIN_ROWS * LINE_WIDTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_e;

  // One-hot write enable for the buffer currently being filled.
  function automatic logic [NUM_LINES-1:0] onehot_sel(input logic [SEL_W-1:0] sel);
    return NUM_LINES'(1) << sel;
  endfunction

  // WIN_ROWS consecutive buffers starting at base, wrapping around the ring.
  function automatic logic [NUM_LINES-1:0] window_mask(input logic [SEL_W-1:0] base);
    logic [NUM_LINES-1:0] m;
    logic [SEL_W-1:0]     idx;
    m = '0;
    for (int k = 0; k < WIN_ROWS; k++) begin
      idx    = SEL_W'((int'(base) + k) % NUM_LINES);
      m[idx] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/line_buffer_sequencer_if.sv
// Handshake and enable bundle between the pixel host, the sequencer and the line-buffer array.
// Latency: n/a (wires only).
// Backpressure: pixel side via o_pixel_ready, window side via i_win_ready.
// Ports: i_pixel_valid/o_pixel_ready (pixel in), i_win_ready (window out accept),
//        o_lb_wr_en/o_lb_rd_en/o_rd_base (buffer control), o_win_valid, o_intr.
interface line_buffer_sequencer_if;
  import line_buffer_sequencer_pkg::*;

  logic                 i_pixel_valid;
  logic                 o_pixel_ready;
  logic                 i_win_ready;
  logic [NUM_LINES-1:0] o_lb_wr_en;
  logic [NUM_LINES-1:0] o_lb_rd_en;
  logic [SEL_W-1:0]     o_rd_base;
  logic                 o_win_valid;
  logic                 o_intr;

  // Host / downstream side.
  modport master (
    output i_pixel_valid, i_win_ready,
    input  o_pixel_ready, o_lb_wr_en, o_lb_rd_en, o_rd_base, o_win_valid, o_intr
  );

  // Sequencer side.
  modport slave (
    input  i_pixel_valid, i_win_ready,
    output o_pixel_ready, o_lb_wr_en, o_lb_rd_en, o_rd_base, o_win_valid, o_intr
  );

endinterface

// File: rtl/line_buffer_sequencer_wrap_counter.sv
// Modulo-N counter with enable; wrap_o flags the enabled step from N-1 back to 0.
// Latency: count updates on the edge after en_i; wrap_o is combinational.
// Backpressure: none, holds its value while en_i is low.
// Ports: clk, rst_n (async active-low), en_i, cnt_o, wrap_o.
module line_buffer_sequencer_wrap_counter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap_o = en_i && (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/line_buffer_sequencer.sv
// Steers pixels into a ring of line buffers and schedules WIN_ROWS-row window reads.
// Latency: write enable same cycle as the pixel; first read 2 cycles after the threshold write.
// Backpressure: o_pixel_ready drops when all buffers are full; i_win_ready low stalls reads.
// Ports: axi_clk, axi_reset_n (async active-low), bus (slave side of the handshake bundle).
module line_buffer_sequencer
  import line_buffer_sequencer_pkg::*;
(
  input  logic                    axi_clk,
  input  logic                    axi_reset_n,
  line_buffer_sequencer_if.slave  bus
);

  state_e            state_q;
  state_e            state_d;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;
  logic              intr_q;

  logic              wr;
  logic              rd;
  logic              wr_line_done;
  logic              rd_line_done;
  logic [SEL_W-1:0]  wr_sel;
  logic [SEL_W-1:0]  rd_base;

  // Only the wrap flags of the column counters and the values of the ring
  // selects are consumed.
  logic [CNT_W-1:0]  wr_cnt_unused;
  logic [CNT_W-1:0]  rd_cnt_unused;
  logic              wr_sel_wrap_unused;
  logic              rd_base_wrap_unused;

  assign bus.o_pixel_ready = (fill_q < FILL_MAX);
  assign wr = bus.i_pixel_valid & bus.o_pixel_ready;
  assign rd = (state_q == ST_READ) & bus.i_win_ready;

  line_buffer_sequencer_wrap_counter #(.N(LINE_WIDTH)) u_wr_cnt (
    .clk    (axi_clk),
    .rst_n  (axi_reset_n),
    .en_i   (wr),
    .cnt_o  (wr_cnt_unused),
    .wrap_o (wr_line_done)
  );

  line_buffer_sequencer_wrap_counter #(.N(NUM_LINES)) u_wr_sel (
    .clk    (axi_clk),
    .rst_n  (axi_reset_n),
    .en_i   (wr_line_done),
    .cnt_o  (wr_sel),
    .wrap_o (wr_sel_wrap_unused)
  );

  line_buffer_sequencer_wrap_counter #(.N(LINE_WIDTH)) u_rd_cnt (
    .clk    (axi_clk),
    .rst_n  (axi_reset_n),
    .en_i   (rd),
    .cnt_o  (rd_cnt_unused),
    .wrap_o (rd_line_done)
  );

  line_buffer_sequencer_wrap_counter #(.N(NUM_LINES)) u_rd_base (
    .clk    (axi_clk),
    .rst_n  (axi_reset_n),
    .en_i   (rd_line_done),
    .cnt_o  (rd_base),
    .wrap_o (rd_base_wrap_unused)
  );

  // The threshold is judged on the registered fill, so the cycle in which it
  // is first met is spent in IDLE and the first read follows one cycle later.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fill_q >= FILL_THRESH) state_d = ST_READ;
      ST_READ: if (rd_line_done)          state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Simultaneous read and write cancel out.
  always_comb begin
    fill_d = fill_q;
    case ({wr, rd})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q <= ST_IDLE;
      fill_q  <= '0;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      intr_q  <= rd_line_done;
    end
  end

  assign bus.o_lb_wr_en  = wr ? onehot_sel(wr_sel) : '0;
  assign bus.o_lb_rd_en  = rd ? window_mask(rd_base) : '0;
  assign bus.o_rd_base   = rd_base;
  assign bus.o_win_valid = rd;
  assign bus.o_intr      = intr_q;

  a_fill_max: assert property (@(posedge axi_clk) disable iff (!axi_reset_n)
    fill_q <= FILL_MAX);
  a_fill_nonneg: assert property (@(posedge axi_clk) disable iff (!axi_reset_n)
    !(rd && !wr && (fill_q == '0)));
  a_en_disjoint: assert property (@(posedge axi_clk) disable iff (!axi_reset_n)
    (bus.o_lb_wr_en & bus.o_lb_rd_en) == '0);

endmodule

// File: tb/tb_line_buffer_sequencer.sv
// Self-checking bench for line_buffer_sequencer against a pixel/line-count reference model.
// Latency: n/a.
// Backpressure: exercised by random and toggling i_win_ready and by filling all buffers.
module tb_line_buffer_sequencer;
  import line_buffer_sequencer_pkg::*;

  localparam int VW = 1 + 2 * NUM_LINES + SEL_W + 2;
  localparam logic [VW-1:0] RST_VEC = {1'b1, {(VW - 1){1'b0}}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  line_buffer_sequencer_if bus();

  line_buffer_sequencer dut (
    .axi_clk     (clk),
    .axi_reset_n (rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model: counts of pixels stored, pixels written, windows finished.
  int      m_fill;
  int      m_wr_total;
  int      m_lines_done;
  int      m_col;
  logic    m_reading;
  logic    m_intr;
  logic    e_wr;
  logic    e_rd;
  logic [VW-1:0] e_vec;

  logic [VW-1:0] obs_vec;
  assign obs_vec = {bus.o_pixel_ready, bus.o_lb_wr_en, bus.o_lb_rd_en,
                    bus.o_rd_base, bus.o_win_valid, bus.o_intr};

  task automatic model_reset();
    m_fill = 0; m_wr_total = 0; m_lines_done = 0; m_col = 0;
    m_reading = 1'b0; m_intr = 1'b0;
  endtask

  // Expected outputs for the current cycle, given the inputs now applied.
  task automatic model_expect();
    int base, pat, rmask;
    logic [NUM_LINES-1:0] ewe, ere;
    logic [SEL_W-1:0] eb;
    logic erdy;
    erdy  = (m_fill < NUM_LINES * LINE_WIDTH);
    e_wr  = bus.i_pixel_valid && erdy;
    e_rd  = m_reading && bus.i_win_ready;
    base  = m_lines_done % NUM_LINES;
    pat   = (1 << WIN_ROWS) - 1;
    rmask = ((pat << base) | (pat >> (NUM_LINES - base))) & ((1 << NUM_LINES) - 1);
    ewe   = e_wr ? NUM_LINES'(1 << ((m_wr_total / LINE_WIDTH) % NUM_LINES)) : '0;
    ere   = e_rd ? NUM_LINES'(rmask) : '0;
    eb    = SEL_W'(base);
    e_vec = {erdy, ewe, ere, eb, e_rd, m_intr};
  endtask

  // Advance the model across the clock edge.
  task automatic model_commit();
    logic last;
    last = e_rd && (m_col == LINE_WIDTH - 1);
    if (!m_reading) m_reading = (m_fill >= WIN_ROWS * LINE_WIDTH);
    else if (last)  m_reading = 1'b0;
    if (e_rd) begin
      m_col = last ? 0 : m_col + 1;
      if (last) m_lines_done++;
    end
    m_intr = last;
    if (e_wr) m_wr_total++;
    m_fill = m_fill + int'(e_wr) - int'(e_rd);
  endtask

  // Apply inputs after the falling edge and compute expectations before the rising edge.
  task automatic cycle(input logic v, input logic r);
    @(negedge clk);
    bus.i_pixel_valid = v;
    bus.i_win_ready   = r;
    #1;
    model_expect();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_pixel_valid = 1'b0;
    bus.i_win_ready   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_pixel_valid = 1'b0;
    bus.i_win_ready   = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (obs_vec !== RST_VEC) begin
      fails++;
      $display("FAIL reset_outputs: got %b want %b", obs_vec, RST_VEC);
    end
    checks++;
    if (dut.fill_q !== '0) begin
      fails++;
      $display("FAIL reset_fill: got %0d want 0", dut.fill_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_fill();
    int sent = 0, last_wr = -1, first_rd = -1, last_rd = -1;
    int n_0111 = 0, n_intr = 0, intr_cyc = -1;
    reset_dut();
    for (int cyc = 0; cyc < 2400; cyc++) begin
      cycle(sent < WIN_ROWS * LINE_WIDTH, 1'b1);
      checks++;
      if (obs_vec !== e_vec) begin
        fails++;
        $display("FAIL fill_cycle %0d: got %b want %b", cyc, obs_vec, e_vec);
      end
      if (e_wr) sent++;
      if (bus.o_lb_wr_en != '0) last_wr = cyc;
      if (bus.o_win_valid) begin
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        if (bus.o_lb_rd_en == 4'b0111) n_0111++;
      end
      if (bus.o_intr) begin
        n_intr++;
        if (intr_cyc < 0) intr_cyc = cyc;
      end
      model_commit();
      if (intr_cyc >= 0 && cyc > intr_cyc + 3) break;
    end
    // One cycle for fill to register the threshold, one for the FSM to enter READ.
    checks++;
    if (first_rd - last_wr !== 2) begin
      fails++;
      $display("FAIL fill_first_read_gap: got %0d want 2", first_rd - last_wr);
    end
    checks++;
    if (n_0111 !== LINE_WIDTH) begin
      fails++;
      $display("FAIL fill_reads_0111: got %0d want %0d", n_0111, LINE_WIDTH);
    end
    checks++;
    if (intr_cyc - last_rd !== 1) begin
      fails++;
      $display("FAIL fill_intr_timing: got %0d want 1", intr_cyc - last_rd);
    end
    checks++;
    if (n_intr !== 1) begin
      fails++;
      $display("FAIL fill_intr_count: got %0d want 1", n_intr);
    end
  endtask

  // Continues from test_fill: the host sends one line per consumed line.
  task automatic test_steady();
    logic [3:0] rd_tab [4];
    logic [3:0] wr_tab [4];
    int owed, target;
    logic v, r;
    rd_tab = '{4'b0111, 4'b1110, 4'b1101, 4'b1011};
    wr_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    owed   = m_lines_done - (m_wr_total / LINE_WIDTH - WIN_ROWS);
    target = m_lines_done + 12;
    for (int cyc = 0; cyc < 40000 && m_lines_done < target; cyc++) begin
      v = (owed > 0) && ($urandom_range(3) != 0);
      r = ($urandom_range(3) != 0);
      cycle(v, r);
      checks++;
      if (obs_vec !== e_vec) begin
        fails++;
        $display("FAIL steady_cycle %0d: got %b want %b", cyc, obs_vec, e_vec);
      end
      if (e_rd && m_col == 0) begin
        checks++;
        if (bus.o_lb_rd_en !== rd_tab[m_lines_done % 4]) begin
          fails++;
          $display("FAIL steady_rd_en line %0d: got %b want %b",
                   m_lines_done, bus.o_lb_rd_en, rd_tab[m_lines_done % 4]);
        end
      end
      if (e_wr && (m_wr_total % LINE_WIDTH) == 0) begin
        checks++;
        if (bus.o_lb_wr_en !== wr_tab[(m_wr_total / LINE_WIDTH) % 4]) begin
          fails++;
          $display("FAIL steady_wr_en line %0d: got %b want %b", m_wr_total / LINE_WIDTH,
                   bus.o_lb_wr_en, wr_tab[(m_wr_total / LINE_WIDTH) % 4]);
        end
      end
      if (m_intr) owed++;
      model_commit();
      if (e_wr && (m_wr_total % LINE_WIDTH) == 0) owed--;
    end
    checks++;
    if (m_lines_done < target) begin
      fails++;
      $display("FAIL steady_timeout: got %0d lines want %0d", m_lines_done, target);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0, first_rd = -1, n_rd = 0, intr_cyc = -1;
    logic phase = 1'b0;
    reset_dut();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      cycle(sent < WIN_ROWS * LINE_WIDTH, phase);
      phase = ~phase;
      checks++;
      if (obs_vec !== e_vec) begin
        fails++;
        $display("FAIL bp_cycle %0d: got %b want %b", cyc, obs_vec, e_vec);
      end
      checks++;
      if (dut.fill_q !== FILL_W'(m_fill)) begin
        fails++;
        $display("FAIL bp_fill %0d: got %0d want %0d", cyc, dut.fill_q, m_fill);
      end
      if (e_wr) sent++;
      if (bus.o_win_valid) begin
        if (first_rd < 0) first_rd = cyc;
        n_rd++;
      end
      if (bus.o_intr && intr_cyc < 0) intr_cyc = cyc;
      model_commit();
      if (intr_cyc >= 0 && cyc > intr_cyc + 2) break;
    end
    checks++;
    if (n_rd !== LINE_WIDTH) begin
      fails++;
      $display("FAIL bp_read_count: got %0d want %0d", n_rd, LINE_WIDTH);
    end
    checks++;
    if (intr_cyc - first_rd !== 2 * LINE_WIDTH - 1) begin
      fails++;
      $display("FAIL bp_intr_delay: got %0d want %0d", intr_cyc - first_rd, 2 * LINE_WIDTH - 1);
    end
  endtask

  task automatic test_full();
    int n_wr = 0, first_rd = -1, ready_cyc = -1, intr_cyc = -1;
    reset_dut();
    for (int cyc = 0; cyc < NUM_LINES * LINE_WIDTH + 16; cyc++) begin
      cycle(1'b1, 1'b0);
      checks++;
      if (obs_vec !== e_vec) begin
        fails++;
        $display("FAIL full_cycle %0d: got %b want %b", cyc, obs_vec, e_vec);
      end
      if (bus.o_lb_wr_en != '0) n_wr++;
      model_commit();
    end
    checks++;
    if (n_wr !== NUM_LINES * LINE_WIDTH) begin
      fails++;
      $display("FAIL full_write_count: got %0d want %0d", n_wr, NUM_LINES * LINE_WIDTH);
    end
    checks++;
    if (bus.o_pixel_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_ready: got %b want 0", bus.o_pixel_ready);
    end
    checks++;
    if (dut.fill_q !== FILL_W'(NUM_LINES * LINE_WIDTH)) begin
      fails++;
      $display("FAIL full_fill: got %0d want %0d", dut.fill_q, NUM_LINES * LINE_WIDTH);
    end
    for (int cyc = 0; cyc < 700; cyc++) begin
      cycle(1'b0, 1'b1);
      checks++;
      if (obs_vec !== e_vec) begin
        fails++;
        $display("FAIL full_drain_cycle %0d: got %b want %b", cyc, obs_vec, e_vec);
      end
      if (bus.o_win_valid && first_rd < 0) first_rd = cyc;
      if (first_rd >= 0 && ready_cyc < 0 && bus.o_pixel_ready) ready_cyc = cyc;
      if (bus.o_intr && intr_cyc < 0) intr_cyc = cyc;
      model_commit();
      if (intr_cyc >= 0) break;
    end
    checks++;
    if (first_rd < 0 || ready_cyc - first_rd !== 1) begin
      fails++;
      $display("FAIL full_ready_return: got %0d want 1 (first read %0d)",
               ready_cyc - first_rd, first_rd);
    end
  endtask

  task automatic test_reset_mid();
    int sent = 0, n_intr = 0, hit = 0, rd_seen = 0;
    logic [NUM_LINES-1:0] first_wr_en = '0, first_rd_en = '0;
    reset_dut();
    for (int cyc = 0; cyc < 2400 && hit == 0; cyc++) begin
      cycle(sent < WIN_ROWS * LINE_WIDTH, 1'b1);
      checks++;
      if (obs_vec !== e_vec) begin
        fails++;
        $display("FAIL midrst_cycle %0d: got %b want %b", cyc, obs_vec, e_vec);
      end
      if (e_wr) sent++;
      if (e_rd && m_col == 200) begin
        hit = 1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_vec !== RST_VEC) begin
          fails++;
          $display("FAIL midrst_outputs: got %b want %b", obs_vec, RST_VEC);
        end
      end else begin
        model_commit();
      end
    end
    checks++;
    if (hit == 0) begin
      fails++;
      $display("FAIL midrst_reach_col200: got no read at column 200");
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sent = 0;
    for (int cyc = 0; cyc < 2400 && rd_seen < 3; cyc++) begin
      cycle(sent < WIN_ROWS * LINE_WIDTH, 1'b1);
      checks++;
      if (obs_vec !== e_vec) begin
        fails++;
        $display("FAIL midrst_refill_cycle %0d: got %b want %b", cyc, obs_vec, e_vec);
      end
      if (bus.o_intr) n_intr++;
      if (sent == 0 && e_wr) first_wr_en = bus.o_lb_wr_en;
      if (e_wr) sent++;
      if (bus.o_win_valid) begin
        if (rd_seen == 0) first_rd_en = bus.o_lb_rd_en;
        rd_seen++;
      end
      model_commit();
    end
    checks++;
    if (n_intr !== 0) begin
      fails++;
      $display("FAIL midrst_no_intr: got %0d pulses want 0", n_intr);
    end
    checks++;
    if (first_wr_en !== 4'b0001) begin
      fails++;
      $display("FAIL midrst_first_wr_en: got %b want 0001", first_wr_en);
    end
    checks++;
    if (first_rd_en !== 4'b0111) begin
      fails++;
      $display("FAIL midrst_first_rd_en: got %b want 0111", first_rd_en);
    end
  endtask

  initial begin
    bus.i_pixel_valid = 1'b0;
    bus.i_win_ready   = 1'b0;
    model_reset();
    test_reset();
    test_fill();
    test_steady();
    test_backpressure();
    test_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
